// File: rtl/mem_byte_bridge.sv
// mem_byte_bridge: services 32-bit word requests over a byte-wide
// synchronous SRAM/MMIO port, one byte transfer per cycle.
module mem_byte_bridge #(
    parameter int ADDR_WIDTH = 14,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [3:0]            req_wen,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic [ADDR_WIDTH+1:0] mem_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_ISSUE,
        READ_WAIT,
        RESP
    } state_t;

    localparam logic [1:0] WLAST = 2'(RD_LATENCY - 1);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            mask_q;
    logic [31:0]           wdata_q;
    logic [1:0]            lane_q;
    logic [1:0]            wait_q;
    logic [31:0]           asm_q;
    logic                  req_ready_q;
    logic                  resp_valid_q;
    logic [31:0]           resp_rdata_q;
    logic [ADDR_WIDTH+1:0] mem_addr_q;
    logic                  mem_we_q;
    logic                  mem_re_q;
    logic [7:0]            mem_wdata_q;

    logic [1:0]            flane_d;
    logic [1:0]            wlane_d;
    logic [3:0]            fmask_d;
    logic [3:0]            wmask_d;
    logic [1:0]            lane_d;
    logic [31:0]           asm_d;

    function automatic logic [1:0] low_lane(input logic [3:0] m);
        if (m[0]) return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else return 2'd3;
    endfunction

    // Lowest pending lane, remaining mask and assembled read word.
    always_comb begin
        flane_d = low_lane(req_wen);
        fmask_d = req_wen & (req_wen - 4'd1);
        wlane_d = low_lane(mask_q);
        wmask_d = mask_q & (mask_q - 4'd1);
        lane_d  = lane_q + 2'd1;
        asm_d   = asm_q;
        asm_d[{lane_q, 3'b000} +: 8] = mem_rdata;
    end

    // Control FSM; every port output is a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            mask_q       <= '0;
            wdata_q      <= '0;
            lane_q       <= '0;
            wait_q       <= '0;
            asm_q        <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_wdata_q  <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        if (req_wen != 4'd0) begin
                            state_q     <= WRITE;
                            mask_q      <= fmask_d;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {req_addr, flane_d};
                            mem_wdata_q <= req_wdata[{flane_d, 3'b000} +: 8];
                        end else begin
                            state_q    <= READ_ISSUE;
                            lane_q     <= 2'd0;
                            asm_q      <= '0;
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= {req_addr, 2'd0};
                        end
                    end
                end
                WRITE: begin
                    if (mask_q == 4'd0) begin
                        state_q      <= RESP;
                        mem_we_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= '0;
                    end else begin
                        mask_q      <= wmask_d;
                        mem_addr_q  <= {addr_q, wlane_d};
                        mem_wdata_q <= wdata_q[{wlane_d, 3'b000} +: 8];
                    end
                end
                READ_ISSUE: begin
                    state_q  <= READ_WAIT;
                    mem_re_q <= 1'b0;
                    wait_q   <= 2'd0;
                end
                READ_WAIT: begin
                    if (wait_q == WLAST) begin
                        asm_q <= asm_d;
                        if (lane_q == 2'd3) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= asm_d;
                        end else begin
                            state_q    <= READ_ISSUE;
                            lane_q     <= lane_d;
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= {addr_q, lane_d};
                        end
                    end else begin
                        wait_q <= wait_q + 2'd1;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_re     = mem_re_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_byte_bridge.sv
// tb_mem_byte_bridge: scoreboard bench for mem_byte_bridge with
// byte memory models at read latencies 1 (u0) and 3 (u1).
module tb_mem_byte_bridge;

    typedef struct packed {
        int          inst;
        logic [31:0] rd;
        int          c;
    } exp_t;

    typedef struct packed {
        int          c;
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid;
    int          sel;
    logic [13:0] req_addr;
    logic [3:0]  req_wen;
    logic [31:0] req_wdata;

    logic [1:0]        vin;
    logic [1:0]        req_ready;
    logic [1:0]        resp_valid;
    logic [1:0]        mem_we;
    logic [1:0]        mem_re;
    logic [1:0][31:0]  resp_rdata;
    logic [1:0][15:0]  mem_addr;
    logic [1:0][7:0]   mem_wdata;
    logic [1:0][7:0]   mem_rdata;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int acc_cnt = 0;
    int acc_edge = 0;
    int rsp_cnt = 0;
    logic [31:0] exp_rd = '0;
    int exp_lat = 0;

    exp_t sbq[$];
    wr_t  wlog[$];
    int   rlog[$];
    int   acc_edges[$];

    logic [7:0] mem [2][256];
    logic [7:0] pipe [2][4];

    assign vin[0] = req_valid && (sel == 0);
    assign vin[1] = req_valid && (sel == 1);
    assign mem_rdata[0] = pipe[0][0];
    assign mem_rdata[1] = pipe[1][2];

    mem_byte_bridge #(.ADDR_WIDTH(14), .RD_LATENCY(1)) u0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(vin[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr), .req_wen(req_wen),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
        .mem_addr(mem_addr[0]), .mem_we(mem_we[0]),
        .mem_re(mem_re[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0])
    );

    mem_byte_bridge #(.ADDR_WIDTH(14), .RD_LATENCY(3)) u1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(vin[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr), .req_wen(req_wen),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
        .mem_addr(mem_addr[1]), .mem_we(mem_we[1]),
        .mem_re(mem_re[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1])
    );

    function automatic void chk(input string n,
                                input logic [63:0] act,
                                input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", n, act, exp);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Byte memory models: preload, write capture, read latency pipe.
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 256; j++) mem[i][j] = 8'h00;
                mem[i][8'h20] = 8'h11;
                mem[i][8'h21] = 8'h22;
                mem[i][8'h22] = 8'h33;
                mem[i][8'h23] = 8'h44;
                mem[i][8'h0D] = 8'h5A;
                mem[i][8'h0F] = 8'hA5;
            end
        end
        for (int i = 0; i < 2; i++) begin
            for (int j = 3; j > 0; j--) pipe[i][j] <= pipe[i][j-1];
            pipe[i][0] <= mem_re[i] ? mem[i][mem_addr[i][7:0]] : 8'h00;
            if (mem_we[i]) begin
                mem[i][mem_addr[i][7:0]] = mem_wdata[i];
                wlog.push_back('{cyc, mem_addr[i], mem_wdata[i]});
            end
            if (mem_re[i]) rlog.push_back(cyc);
        end
    end

    // Accept observer: pushes the expected response on each handshake.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (vin[i] && req_ready[i]) begin
                sbq.push_back('{i, exp_rd, cyc + exp_lat});
                acc_cnt++;
                acc_edge = cyc;
                acc_edges.push_back(cyc);
            end
        end
    end

    // Response monitor: pops and compares every resp_valid pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (mem_we[i] && mem_re[i]) begin
                    total++;
                    bad++;
                    $display("FAIL strobe_overlap inst=%0d cyc=%0d", i, cyc);
                end
                if (resp_valid[i]) begin
                    rsp_cnt++;
                    if (sbq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_resp inst=%0d got=%0h",
                                 i, resp_rdata[i]);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk("resp_inst", 64'(i), 64'(e.inst));
                        chk("resp_rdata", 64'(resp_rdata[i]), 64'(e.rd));
                        chk("resp_cycle", 64'(cyc), 64'(e.c));
                    end
                end
            end
        end
    end

    task automatic issue(input int i, input logic [13:0] a,
                         input logic [3:0] w, input logic [31:0] d,
                         input logic [31:0] erd, input int elat,
                         input int hold);
        int n;
        int a0;
        @(negedge clk);
        sel = i;
        req_addr = a;
        req_wen = w;
        req_wdata = d;
        exp_rd = erd;
        exp_lat = elat;
        wlog.delete();
        rlog.delete();
        a0 = acc_cnt;
        req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((acc_cnt == a0 || n < hold) && n < 300);
        req_valid = 1'b0;
        if (acc_cnt == a0) begin
            total++;
            bad++;
            $display("FAIL accept_timeout got=none want=accept");
        end
        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL resp_timeout got=none want=%0d", sbq.size());
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_wr(input string n, input int cnt,
                          input logic [3:0][15:0] ea,
                          input logic [3:0][7:0] ed);
        chk({n, "_cnt"}, 64'(wlog.size()), 64'(cnt));
        for (int k = 0; k < cnt; k++) begin
            if (k < wlog.size()) begin
                chk({n, "_cyc"}, 64'(wlog[k].c), 64'(acc_edge + 1 + k));
                chk({n, "_addr"}, 64'(wlog[k].a), 64'(ea[k]));
                chk({n, "_data"}, 64'(wlog[k].d), 64'(ed[k]));
            end
        end
    endtask

    task automatic chk_rd(input string n, input int step);
        chk({n, "_cnt"}, 64'(rlog.size()), 64'(4));
        for (int k = 0; k < 4; k++) begin
            if (k < rlog.size())
                chk({n, "_cyc"}, 64'(rlog[k]), 64'(acc_edge + 1 + k * step));
        end
    endtask

    task automatic chk_idle_outs(input string n);
        for (int i = 0; i < 2; i++) begin
            chk({n, "_ctl"},
                64'({req_ready[i], resp_valid[i], mem_we[i], mem_re[i]}),
                64'(0));
            chk({n, "_bus"}, 64'({mem_addr[i], mem_wdata[i]}), 64'(0));
            chk({n, "_rdata"}, 64'(resp_rdata[i]), 64'(0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        int a0;
        int r0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        sel = 0;
        req_addr = '0;
        req_wen = '0;
        req_wdata = '0;

        repeat (3) @(negedge clk);
        chk_idle_outs("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready0", 64'(req_ready[0]), 64'(1));
        chk("rst_ready1", 64'(req_ready[1]), 64'(1));
        chk("rst_resp", 64'(resp_valid), 64'(0));

        issue(0, 14'h0010, 4'b1111, 32'hAABBCCDD, 32'h0, 5, 1);
        chk_wr("full", 4, {16'h43, 16'h42, 16'h41, 16'h40},
               {8'hAA, 8'hBB, 8'hCC, 8'hDD});

        issue(0, 14'h0003, 4'b0101, 32'h11223344, 32'h0, 3, 1);
        chk_wr("sparse", 2, {16'h0, 16'h0, 16'h0E, 16'h0C},
               {8'h0, 8'h0, 8'h22, 8'h44});

        issue(0, 14'h0005, 4'b1000, 32'h77665544, 32'h0, 2, 1);
        chk_wr("lane3", 1, {16'h0, 16'h0, 16'h0, 16'h17},
               {8'h0, 8'h0, 8'h0, 8'h77});

        issue(0, 14'h0008, 4'b0000, 32'hFFFFFFFF, 32'h44332211, 9, 1);
        chk_rd("rd_l1", 2);
        chk("rd_l1_nowe", 64'(wlog.size()), 64'(0));

        issue(1, 14'h0008, 4'b0000, 32'h0, 32'h44332211, 17, 1);
        chk_rd("rd_l3", 4);

        issue(0, 14'h0010, 4'b0000, 32'h0, 32'hAABBCCDD, 9, 1);
        issue(0, 14'h0003, 4'b0000, 32'h0, 32'hA5225A44, 9, 1);
        issue(0, 14'h0005, 4'b0000, 32'h0, 32'h77000000, 9, 1);

        a0 = acc_cnt;
        r0 = rsp_cnt;
        acc_edges.delete();
        issue(0, 14'h0002, 4'b1111, 32'h01020304, 32'h0, 5, 20);
        chk("busy_accepts", 64'(acc_cnt - a0), 64'(4));
        chk("busy_resps", 64'(rsp_cnt - r0), 64'(4));
        chk("busy_writes", 64'(wlog.size()), 64'(16));
        if (acc_edges.size() >= 2)
            chk("busy_gap", 64'(acc_edges[1] - acc_edges[0]), 64'(6));

        @(negedge clk);
        sel = 0;
        req_addr = 14'h0008;
        req_wen = 4'b0000;
        exp_rd = 32'h44332211;
        exp_lat = 9;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_re_c1", 64'(mem_re[0]), 64'(1));
        repeat (5) @(negedge clk);
        chk("mid_wait", 64'({mem_re[0], mem_we[0], resp_valid[0]}), 64'(0));
        chk("mid_waddr", 64'(mem_addr[0]), 64'(16'h22));
        r0 = rsp_cnt;
        rst_n = 1'b0;
        #1;
        sbq.delete();
        chk_idle_outs("mid_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("mid_noresp", 64'(rsp_cnt - r0), 64'(0));
        issue(0, 14'h0008, 4'b0000, 32'h0, 32'h44332211, 9, 1);
        chk_rd("mid_rd", 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
